// File: rtl/xbar_rr_ordered.sv
// MASTERS x SLAVES data-bus crossbar with per-slave round-robin arbitration,
// response routing FIFOs, in-order decode-error responses and a per-master ordering guard.
module xbar_rr_ordered #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned MASTER_ADDR_WIDTH = 12,
  parameter int unsigned SLAVE_ADDR_WIDTH  = 10,
  parameter int unsigned MASTERS           = 4,
  parameter int unsigned SLAVES            = 3,
  parameter logic [SLAVES*MASTER_ADDR_WIDTH-1:0] ADDR_MATCH = {12'h800, 12'h400, 12'h000},
  parameter logic [SLAVES*MASTER_ADDR_WIDTH-1:0] ADDR_MASK  = {12'hC00, 12'hC00, 12'hC00},
  parameter int unsigned MAX_OUTSTANDING   = 2,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [MASTERS-1:0]                    master_data_req_i,
  input  logic [MASTERS*MASTER_ADDR_WIDTH-1:0]  master_data_addr_i,
  input  logic [MASTERS-1:0]                    master_data_we_i,
  input  logic [MASTERS*DATA_WIDTH/8-1:0]       master_data_be_i,
  input  logic [MASTERS*DATA_WIDTH-1:0]         master_data_wdata_i,
  output logic [MASTERS-1:0]                    master_data_gnt_o,
  output logic [MASTERS-1:0]                    master_data_rvalid_o,
  output logic [MASTERS*DATA_WIDTH-1:0]         master_data_rdata_o,
  output logic [MASTERS-1:0]                    master_data_err_o,
  output logic [SLAVES-1:0]                     slave_data_req_o,
  output logic [SLAVES*SLAVE_ADDR_WIDTH-1:0]    slave_data_addr_o,
  output logic [SLAVES-1:0]                     slave_data_we_o,
  output logic [SLAVES*DATA_WIDTH/8-1:0]        slave_data_be_o,
  output logic [SLAVES*DATA_WIDTH-1:0]          slave_data_wdata_o,
  input  logic [SLAVES-1:0]                     slave_data_gnt_i,
  input  logic [SLAVES-1:0]                     slave_data_rvalid_i,
  input  logic [SLAVES*DATA_WIDTH-1:0]          slave_data_rdata_i
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned MAW      = MASTER_ADDR_WIDTH;
  localparam int unsigned SAW      = SLAVE_ADDR_WIDTH;
  localparam int unsigned MW       = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int unsigned SW       = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int unsigned PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW       = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [MAW-1:0]        addr;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t                        m_req     [MASTERS];
  logic [SW-1:0]               m_tgt     [MASTERS];
  logic [MASTERS-1:0]          m_hit;
  logic [MASTERS-1:0]          miss_gnt;
  logic [MASTERS-1:0]          m_inc;
  logic [MASTERS-1:0]          m_dec;
  logic [SLAVES-1:0][MASTERS-1:0] elig;
  logic [SLAVES-1:0]           win_valid;
  logic [MW-1:0]               win_idx   [SLAVES];
  logic [SLAVES-1:0]           fifo_full;
  logic [MW-1:0]               fifo_head [SLAVES];
  logic [SLAVES-1:0]           s_req;
  logic [SLAVES-1:0]           s_accept;
  logic [SLAVES-1:0]           s_rsp;

  logic [MW-1:0]               fifo_mem  [SLAVES][MAX_OUTSTANDING];
  logic [PW-1:0]               wr_ptr    [SLAVES];
  logic [PW-1:0]               rd_ptr    [SLAVES];
  logic [CW-1:0]               fifo_cnt  [SLAVES];
  logic [MW-1:0]               rr_ptr    [SLAVES];
  logic [CW-1:0]               out_cnt   [MASTERS];
  logic [SW-1:0]               last_tgt  [MASTERS];
  logic [MASTERS-1:0]          err_pend;

  function automatic logic [MW-1:0] rr_idx(input logic [MW-1:0] base, input int unsigned off);
    return MW'((32'(base) + off) % MASTERS);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : PW'(32'(p) + 1);
  endfunction

  // Unpack master payloads and decode targets; lowest matching slave wins.
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      m_req[m].addr  = master_data_addr_i[m*MAW +: MAW];
      m_req[m].we    = master_data_we_i[m];
      m_req[m].be    = master_data_be_i[m*BE_WIDTH +: BE_WIDTH];
      m_req[m].wdata = master_data_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
      m_hit[m]       = 1'b0;
      m_tgt[m]       = '0;
      for (int s = SLAVES - 1; s >= 0; s--) begin
        if ((master_data_addr_i[m*MAW +: MAW] & ADDR_MASK[s*MAW +: MAW]) == ADDR_MATCH[s*MAW +: MAW]) begin
          m_hit[m] = 1'b1;
          m_tgt[m] = SW'(s);
        end
      end
      miss_gnt[m] = master_data_req_i[m] && !m_hit[m] && (out_cnt[m] == '0);
    end
  end

  // A master may only add to its outstanding set on the slave it already waits on.
  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      for (int m = 0; m < MASTERS; m++) begin
        elig[s][m] = master_data_req_i[m] && m_hit[m] && (m_tgt[m] == SW'(s)) &&
                     (out_cnt[m] < CW'(MAX_OUTSTANDING)) &&
                     ((out_cnt[m] == '0) || (last_tgt[m] == SW'(s)));
      end
    end
  end

  // Round-robin search starting at rr_ptr.
  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      win_valid[s] = 1'b0;
      win_idx[s]   = '0;
      for (int unsigned i = 0; i < MASTERS; i++) begin
        if (!win_valid[s] && elig[s][rr_idx(rr_ptr[s], i)]) begin
          win_valid[s] = 1'b1;
          win_idx[s]   = rr_idx(rr_ptr[s], i);
        end
      end
    end
  end

  // Slave-side mux and routing FIFO status.
  always_comb begin
    slave_data_req_o   = '0;
    slave_data_addr_o  = '0;
    slave_data_we_o    = '0;
    slave_data_be_o    = '0;
    slave_data_wdata_o = '0;
    for (int s = 0; s < SLAVES; s++) begin
      fifo_full[s] = (fifo_cnt[s] == CW'(MAX_OUTSTANDING));
      fifo_head[s] = fifo_mem[s][rd_ptr[s]];
      s_req[s]     = win_valid[s] && !fifo_full[s];
      s_accept[s]  = s_req[s] && slave_data_gnt_i[s];
      s_rsp[s]     = slave_data_rvalid_i[s] && (fifo_cnt[s] != '0);
      if (s_req[s]) begin
        slave_data_req_o[s]                           = 1'b1;
        slave_data_addr_o[s*SAW +: SAW]               = m_req[win_idx[s]].addr[SAW-1:0];
        slave_data_we_o[s]                            = m_req[win_idx[s]].we;
        slave_data_be_o[s*BE_WIDTH +: BE_WIDTH]       = m_req[win_idx[s]].be;
        slave_data_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] = m_req[win_idx[s]].wdata;
      end
    end
  end

  // Master-side grant and response steering.
  always_comb begin
    master_data_gnt_o    = '0;
    master_data_rvalid_o = '0;
    master_data_rdata_o  = '0;
    master_data_err_o    = '0;
    m_inc                = '0;
    m_dec                = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (miss_gnt[m]) begin
        master_data_gnt_o[m] = 1'b1;
        m_inc[m]             = 1'b1;
      end
      if (err_pend[m]) begin
        master_data_rvalid_o[m]                         = 1'b1;
        master_data_err_o[m]                            = 1'b1;
        master_data_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = ERR_RDATA;
        m_dec[m]                                        = 1'b1;
      end
      for (int s = 0; s < SLAVES; s++) begin
        if (s_accept[s] && (win_idx[s] == MW'(m))) begin
          master_data_gnt_o[m] = 1'b1;
          m_inc[m]             = 1'b1;
        end
        if (s_rsp[s] && (fifo_head[s] == MW'(m))) begin
          master_data_rvalid_o[m]                         = 1'b1;
          master_data_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = slave_data_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
          m_dec[m]                                        = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SLAVES; s++) begin
        for (int d = 0; d < MAX_OUTSTANDING; d++) begin
          fifo_mem[s][d] <= '0;
        end
        wr_ptr[s]   <= '0;
        rd_ptr[s]   <= '0;
        fifo_cnt[s] <= '0;
        rr_ptr[s]   <= '0;
      end
      for (int m = 0; m < MASTERS; m++) begin
        out_cnt[m]  <= '0;
        last_tgt[m] <= '0;
      end
      err_pend <= '0;
    end else begin
      for (int s = 0; s < SLAVES; s++) begin
        if (s_accept[s]) begin
          fifo_mem[s][wr_ptr[s]] <= win_idx[s];
          wr_ptr[s]              <= ptr_inc(wr_ptr[s]);
          rr_ptr[s]              <= rr_idx(win_idx[s], 1);
          last_tgt[win_idx[s]]   <= SW'(s);
        end
        if (s_rsp[s]) begin
          rd_ptr[s] <= ptr_inc(rd_ptr[s]);
        end
        if (s_accept[s] && !s_rsp[s]) begin
          fifo_cnt[s] <= fifo_cnt[s] + CW'(1);
        end else if (!s_accept[s] && s_rsp[s]) begin
          fifo_cnt[s] <= fifo_cnt[s] - CW'(1);
        end
      end
      for (int m = 0; m < MASTERS; m++) begin
        if (m_inc[m] && !m_dec[m]) begin
          out_cnt[m] <= out_cnt[m] + CW'(1);
        end else if (!m_inc[m] && m_dec[m]) begin
          out_cnt[m] <= out_cnt[m] - CW'(1);
        end
      end
      err_pend <= miss_gnt;
    end
  end

endmodule
